// File: rtl/pulse_burst_generator_if.sv
// Handshake bundle for pulse_burst_generator: START/NUM/PERIOD in, PULSE/BUSY/DONE/Remaining out.
// Defining BURST_ABORT_EN adds the ABORT request line.
interface pulse_burst_generator_if #(
    parameter int bitField = 4,
    parameter int perField = 4
);
    logic                START;
    logic [bitField-1:0] NUM;
    logic [perField-1:0] PERIOD;
`ifdef BURST_ABORT_EN
    logic                ABORT;
`endif
    logic                PULSE;
    logic                BUSY;
    logic                DONE;
    logic [bitField-1:0] Remaining;

    modport master (
`ifdef BURST_ABORT_EN
        output ABORT,
`endif
        output START,
        output NUM,
        output PERIOD,
        input  PULSE,
        input  BUSY,
        input  DONE,
        input  Remaining
    );

    modport slave (
`ifdef BURST_ABORT_EN
        input  ABORT,
`endif
        input  START,
        input  NUM,
        input  PERIOD,
        output PULSE,
        output BUSY,
        output DONE,
        output Remaining
    );
endinterface

// File: rtl/pulse_burst_generator.sv
// Turns one START request into a burst of NUM single-cycle pulses spaced PERIOD cycles apart.
// State advances on the falling CLK edge; optional ABORT input enabled by macro BURST_ABORT_EN.
module pulse_burst_generator #(
    parameter int bitField = 4,
    parameter int perField = 4
) (
    input  logic                    CLK,
    input  logic                    CLEAR,
    pulse_burst_generator_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FIRE, WAIT, FIN} state_t;

    localparam logic [bitField-1:0] REM_ONE  = 1;
    localparam logic [perField-1:0] PER_ONE  = 1;
    localparam logic [perField-1:0] PER_TWO  = 2;

    state_t              r_state;
    logic [bitField-1:0] r_remaining;
    logic [perField-1:0] r_period;
    logic [perField-1:0] r_count;
    logic                r_pulse;
    logic                r_busy;
    logic                r_done;

    logic                w_abort;
    logic [bitField-1:0] w_remDec;
    logic [perField-1:0] w_startPeriod;

`ifdef BURST_ABORT_EN
    assign w_abort = bus.ABORT;
`else
    assign w_abort = 1'b0;
`endif

    assign w_remDec      = r_remaining - REM_ONE;
    // A zero spacing request behaves exactly like back-to-back pulses.
    assign w_startPeriod = (bus.PERIOD == '0) ? PER_ONE : bus.PERIOD;

    always_ff @(negedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_period    <= '0;
            r_count     <= '0;
            r_pulse     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pulse <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    if (bus.START) begin
                        if (bus.NUM != '0) begin
                            r_state     <= FIRE;
                            r_remaining <= bus.NUM;
                            r_period    <= w_startPeriod;
                            r_pulse     <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end

                FIRE: begin
                    if (w_abort || (w_remDec == '0)) begin
                        r_state     <= FIN;
                        r_remaining <= '0;
                        r_pulse     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_remaining <= w_remDec;
                        if (r_period == PER_ONE) begin
                            r_pulse <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_pulse <= 1'b0;
                            r_count <= r_period - PER_TWO;
                        end
                    end
                end

                // The FIRE cycle plus period-1 WAIT cycles gives start-to-start spacing of period.
                WAIT: begin
                    if (w_abort) begin
                        r_state     <= FIN;
                        r_remaining <= '0;
                        r_pulse     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (r_count == '0) begin
                        r_state <= FIRE;
                        r_pulse <= 1'b1;
                    end else begin
                        r_count <= r_count - PER_ONE;
                    end
                end

                FIN: begin
                    r_state     <= IDLE;
                    r_remaining <= '0;
                    r_pulse     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end

                default: begin
                    r_state     <= IDLE;
                    r_remaining <= '0;
                    r_pulse     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PULSE     = r_pulse;
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
    assign bus.Remaining = r_remaining;

endmodule

// File: tb/tb_pulse_burst_generator.sv
// Directed scoreboard bench for pulse_burst_generator; expected per-cycle outputs are
// queued when a burst is launched and popped on each rising CLK edge (DUT updates on falling).
module tb_pulse_burst_generator;

    typedef logic [6:0] obsT;

    logic CLK;
    logic CLEAR;
    int   checkCount;
    int   passCount;
    obsT  expQ[$];

    pulse_burst_generator_if #(.bitField(4), .perField(4)) bus();

    pulse_burst_generator #(.bitField(4), .perField(4)) dut (
        .CLK   (CLK),
        .CLEAR (CLEAR),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic obsT rec(input logic p, input logic b, input logic d, input int r);
        logic [3:0] rv;
        rv = r[3:0];
        return {p, b, d, rv};
    endfunction

    // Build the expected cycle-by-cycle trace from the burst formula.
    task automatic pushBurst(input int n, input int p);
        int pe;
        pe = (p == 0) ? 1 : p;
        if (n > 0) begin
            for (int k = 1; k <= (n - 1) * pe + 1; k++) begin
                expQ.push_back(rec(((k - 1) % pe) == 0, 1'b1, 1'b0,
                                   n - ((k - 1) + pe - 1) / pe));
            end
        end
        expQ.push_back(rec(1'b0, 1'b0, 1'b1, 0));
        expQ.push_back(rec(1'b0, 1'b0, 1'b0, 0));
    endtask

    task automatic checkOutput(input string tag, input int cyc, input obsT expected);
        obsT observed;
        observed = {bus.PULSE, bus.BUSY, bus.DONE, bus.Remaining};
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s cycle %0d: got pulse/busy/done/rem=%b required %b",
                    tag, cyc, observed, expected);
    endtask

    task automatic applyStimulus(input logic start, input int n, input int p);
        logic [3:0] nv;
        logic [3:0] pv;
        nv = n[3:0];
        pv = p[3:0];
        bus.START  = start;
        bus.NUM    = nv;
        bus.PERIOD = pv;
    endtask

    // mode: 0 plain, 1 restart+NUM change after 2nd pulse, 2 CLEAR after 2nd pulse, 3 ABORT after 2nd pulse
    task automatic runBurst(input string tag, input int n, input int p, input int mode);
        int  k;
        obsT e;
        applyStimulus(1'b1, n, p);
        pushBurst(n, p);
        k = 0;
        while (expQ.size() > 0 && k < 600) begin
            @(posedge CLK);
            k++;
            bus.START = 1'b0;
`ifdef BURST_ABORT_EN
            bus.ABORT = 1'b0;
`endif
            e = expQ.pop_front();
            checkOutput(tag, k, e);
            if (k == 4 && mode == 1) begin
                bus.START = 1'b1;
                bus.NUM   = 4'd1;
            end
            if (k == 4 && mode == 2) begin
                expQ.delete();
                #2 CLEAR = 1'b1;
                #1 checkOutput({tag, "_clrNow"}, k, rec(1'b0, 1'b0, 1'b0, 0));
                for (int i = 0; i < 3; i++) begin
                    @(posedge CLK);
                    checkOutput({tag, "_clrHold"}, k + 1 + i, rec(1'b0, 1'b0, 1'b0, 0));
                end
                CLEAR = 1'b0;
                @(posedge CLK);
                checkOutput({tag, "_clrAfter"}, k + 4, rec(1'b0, 1'b0, 1'b0, 0));
            end
`ifdef BURST_ABORT_EN
            if (k == 4 && mode == 3) begin
                bus.ABORT = 1'b1;
                expQ.delete();
                expQ.push_back(rec(1'b0, 1'b0, 1'b1, 0));
                expQ.push_back(rec(1'b0, 1'b0, 1'b0, 0));
                expQ.push_back(rec(1'b0, 1'b0, 1'b0, 0));
            end
`endif
        end
        checkCount++;
        assert (expQ.size() == 0) passCount++;
        else $error("[TB] FAIL %s_timeout: %0d entries left, required 0", tag, expQ.size());
        expQ.delete();
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        CLEAR      = 1'b1;
        applyStimulus(1'b0, 0, 0);
`ifdef BURST_ABORT_EN
        bus.ABORT = 1'b0;
`endif
        #1 checkOutput("reset", 0, rec(1'b0, 1'b0, 1'b0, 0));
        repeat (2) @(posedge CLK);
        CLEAR = 1'b0;

        runBurst("n3p4", 3, 4, 0);
        runBurst("n4p1", 4, 1, 0);
        runBurst("n4p0", 4, 0, 0);
        runBurst("n0", 0, 5, 0);
        runBurst("n2p2", 2, 2, 0);
        runBurst("n5p3_restart", 5, 3, 1);
        runBurst("n5p3_clear", 5, 3, 2);
        runBurst("n15p15_max", 15, 15, 0);
`ifdef BURST_ABORT_EN
        runBurst("n5p3_abort", 5, 3, 3);
`endif
        runBurst("n1p7", 1, 7, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
